mio_bus: RTL and testbench
==========================

Name: mio_bus

Overview:
- Memory/IO bus controller directly downstream of the multicycle CPU.
- Consumes the CPU bus request (CPU_MIO, mem_w, address, write data) and decodes it to three targets: a synchronous block RAM, an LED/switch port, and a programmable down-counter.
- Returns read data and the MIO_ready handshake to the CPU, and inserts a configurable number of wait states for RAM accesses.

Parameters:
- RAM_WAIT, 2, RAM wait cycles per access; legal range 1..15.
- RAM_AW, 10, RAM word-address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- CPU_MIO  in  1  request strobe from CPU; held high until MIO_ready is seen.
- mem_w  in  1  1 = write, 0 = read; sampled at acceptance.
- Addr_bus  in  32  byte address from CPU; sampled at acceptance.
- Data_from_CPU  in  32  write data; sampled at acceptance.
- Data_to_CPU  out  32  read data to CPU; valid while MIO_ready=1, held until next acceptance.
- MIO_ready  out  1  one-cycle completion pulse, registered.
- ram_addr  out  RAM_AW  word address, equal to captured Addr_bus[RAM_AW+1:2].
- ram_we  out  1  RAM write enable.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data; 1-cycle synchronous read.
- sw  in  16  switch inputs.
- led  out  16  LED register.
- cnt_zero  out  1  high while counter = 0.

Behaviour:
- Address map, decoded on captured Addr_bus[31:28]:
  - 0x0 = RAM.
  - 0xE = IO port. Write: led <= Data[15:0]. Read: {16'h0, sw}.
  - 0xF = counter. Write: load the counter. Read: counter value.
  - Any other value = unmapped. Write is ignored; read returns 0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE with CPU_MIO=1: accept the request. Capture address, data and mem_w, and latch the decoded target.
  - On accept, go to WAIT if the target is RAM; otherwise go to RESP.
  - WAIT: a 4-bit wait counter loads RAM_WAIT-1 on entry and decrements each cycle. Go to RESP when it reaches 0 (exactly RAM_WAIT cycles spent in WAIT).
  - RESP: MIO_ready=1 for exactly this one cycle, then return to IDLE unconditionally.
  - The requester drops CPU_MIO in the cycle after MIO_ready. If CPU_MIO is still high in IDLE, it is a new request.
- Latency, with acceptance at cycle 0:
  - IO, counter and unmapped accesses: MIO_ready in cycle 1.
  - RAM accesses: MIO_ready in cycle 1+RAM_WAIT.
- RAM interface:
  - ram_addr and ram_din are stable from the cycle after acceptance through RESP.
  - ram_we=1 only in the first WAIT cycle of a write; never more than one cycle per access.
  - For a read, Data_to_CPU is registered from ram_dout on the WAIT->RESP transition. RAM_WAIT>=1 guarantees the data is valid.
- IO and counter side effects take effect on the acceptance edge. Read data is registered on that same edge and reflects pre-write values.
- Counter:
  - 32-bit down-counter; decrements by 1 each cycle when nonzero and stops at 0 (no wrap).
  - A write in the same cycle as a decrement: the load wins, and the new value is visible the next cycle.
  - Loading 0 forces cnt_zero=1 on the next cycle.
- Data_to_CPU updates only on completion of a read. A write leaves the previous value unchanged.
- Reset values:
  - state=IDLE, MIO_ready=0, Data_to_CPU=0.
  - led=0, counter=0 (so cnt_zero=1), ram_we=0, ram_addr=0, ram_din=0.
- Reset mid-access aborts it: no MIO_ready is produced, and a pending ram_we is not issued after reset release.
- No byte enables; all accesses are full 32-bit words. Addr_bus[1:0] is ignored.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> MIO_ready=0, led=0, cnt_zero=1, state IDLE before the next clock edge.
- RAM write then read (RAM_WAIT=2): write 0x0000_0010 <= 0xDEADBEEF -> ram_we high one cycle with ram_addr=4, MIO_ready in cycle 3. Read back 0x10 -> Data_to_CPU=0xDEADBEEF with MIO_ready in cycle 3.
- IO: sw=0x1234, read 0xE000_0000 -> Data_to_CPU=0x0000_1234, MIO_ready in cycle 1. Write 0xE000_0000 <= 0xFFFF_00A5 -> led=0x00A5.
- Counter: write 0xF000_0000 <= 5 -> cnt_zero=0, counter reaches 0 five cycles after load and then holds. Read during count -> value as of acceptance. Load colliding with a decrement -> loaded value wins.
- Unmapped: read 0x5000_0000 -> Data_to_CPU=0, MIO_ready in cycle 1. Write to the same address -> no change to led, counter or RAM.
- Reset mid-access: assert reset during WAIT of a RAM write -> no MIO_ready. After release, a read of the same RAM address returns the old contents (ram_we never pulsed).

Source files
------------

// File: rtl/mio_bus.sv
// -----------------------------------------------------------------------------
// mio_bus -- memory/IO bus controller sitting directly behind the multicycle CPU.
//
// Takes one CPU bus request at a time and routes it to one of three targets:
// a synchronous block RAM, the LED/switch port, or a programmable down-counter.
// It also returns read data and a one-cycle MIO_ready completion pulse.
//
// Address map (captured Addr_bus[31:28]):
//   0x0 RAM      : word address Addr_bus[RAM_AW+1:2]; RAM_WAIT wait cycles
//   0xE IO port  : write -> led <= data[15:0]; read -> {16'h0, sw}
//   0xF counter  : write -> load counter;      read -> counter value
//   other        : write ignored;              read -> 0
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   CPU_MIO              request strobe, held by the CPU until MIO_ready
//   mem_w                1 = write, 0 = read (sampled at acceptance)
//   Addr_bus             byte address (sampled at acceptance)
//   Data_from_CPU        write data (sampled at acceptance)
//   Data_to_CPU          read data, held until the next completed read
//   MIO_ready            registered one-cycle completion pulse
//   ram_addr/we/din      block RAM write/address port
//   ram_dout             block RAM read data (1-cycle synchronous read)
//   sw, led              switch inputs, LED register
//   cnt_zero             high while the down-counter is 0
// -----------------------------------------------------------------------------
module mio_bus #(
    parameter int RAM_WAIT = 2,     // legal range 1..15
    parameter int RAM_AW   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [31:0]       Addr_bus,
    input  logic [31:0]       Data_from_CPU,
    output logic [31:0]       Data_to_CPU,
    output logic              MIO_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw,
    output logic [15:0]       led,
    output logic              cnt_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        T_RAM,
        T_IO,
        T_CNT,
        T_NONE
    } target_t;

    state_t      state_reg;
    logic [3:0]  wait_cnt_reg;
    logic        we_reg;          // captured mem_w, needed for RAM completion
    logic [31:0] cnt_reg;

    target_t     target_dec;
    logic        accept;
    logic        cnt_load;

    // Target decode straight off the bus; it is only consumed on the
    // acceptance edge, so it is effectively decoded from the captured address.
    always_comb begin
        target_dec = T_NONE;
        case (Addr_bus[31:28])
            4'h0:    target_dec = T_RAM;
            4'hE:    target_dec = T_IO;
            4'hF:    target_dec = T_CNT;
            default: target_dec = T_NONE;
        endcase
    end

    assign accept   = (state_reg == S_IDLE) && CPU_MIO;
    assign cnt_load = accept && mem_w && (target_dec == T_CNT);
    assign cnt_zero = (cnt_reg == 32'd0);

    // Request FSM. Only RAM accesses pass through WAIT, so the target does not
    // need to be remembered beyond the acceptance edge: non-RAM side effects
    // and read data are all resolved on that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= 4'd0;
            we_reg       <= 1'b0;
            MIO_ready    <= 1'b0;
            Data_to_CPU  <= 32'd0;
            ram_addr     <= '0;
            ram_we       <= 1'b0;
            ram_din      <= 32'd0;
            led          <= 16'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    MIO_ready <= 1'b0;
                    ram_we    <= 1'b0;
                    if (CPU_MIO) begin
                        we_reg   <= mem_w;
                        ram_addr <= Addr_bus[RAM_AW+1:2];
                        ram_din  <= Data_from_CPU;
                        case (target_dec)
                            T_RAM: begin
                                state_reg    <= S_WAIT;
                                wait_cnt_reg <= 4'(RAM_WAIT - 1);
                                // Write strobe lands in the first WAIT cycle only.
                                ram_we       <= mem_w;
                            end
                            T_IO: begin
                                state_reg <= S_RESP;
                                MIO_ready <= 1'b1;
                                if (mem_w) begin
                                    led <= Data_from_CPU[15:0];
                                end else begin
                                    Data_to_CPU <= {16'h0000, sw};
                                end
                            end
                            T_CNT: begin
                                state_reg <= S_RESP;
                                MIO_ready <= 1'b1;
                                // Load handled in the counter block; a read
                                // returns the value before this edge.
                                if (!mem_w) begin
                                    Data_to_CPU <= cnt_reg;
                                end
                            end
                            default: begin
                                state_reg <= S_RESP;
                                MIO_ready <= 1'b1;
                                if (!mem_w) begin
                                    Data_to_CPU <= 32'd0;
                                end
                            end
                        endcase
                    end
                end
                S_WAIT: begin
                    ram_we <= 1'b0;
                    if (wait_cnt_reg == 4'd0) begin
                        state_reg <= S_RESP;
                        MIO_ready <= 1'b1;
                        if (!we_reg) begin
                            Data_to_CPU <= ram_dout;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                S_RESP: begin
                    MIO_ready <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    MIO_ready <= 1'b0;
                    ram_we    <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Saturating down-counter; a CPU load takes priority over the decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= 32'd0;
        end else if (cnt_load) begin
            cnt_reg <= Data_from_CPU;
        end else if (cnt_reg != 32'd0) begin
            cnt_reg <= cnt_reg - 32'd1;
        end
    end

endmodule

// File: tb/tb_mio_bus.sv
// -----------------------------------------------------------------------------
// tb_mio_bus -- self-checking bench for mio_bus.
// A driver issues CPU requests and pushes the expected response into a
// scoreboard queue; a monitor pops and compares whenever MIO_ready appears.
// The reference model works from the address map: an array for RAM contents,
// a variable for the LEDs, and a closed-form counter (load value and load cycle).
// -----------------------------------------------------------------------------
module tb_mio_bus;

    localparam int RAM_WAIT = 2;
    localparam int RAM_AW   = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              CPU_MIO = 1'b0;
    logic              mem_w = 1'b0;
    logic [31:0]       Addr_bus = 32'd0;
    logic [31:0]       Data_from_CPU = 32'd0;
    logic [31:0]       Data_to_CPU;
    logic              MIO_ready;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;
    logic [15:0]       sw = 16'd0;
    logic [15:0]       led;
    logic              cnt_zero;

    mio_bus #(.RAM_WAIT(RAM_WAIT), .RAM_AW(RAM_AW)) dut (
        .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
        .Addr_bus(Addr_bus), .Data_from_CPU(Data_from_CPU),
        .Data_to_CPU(Data_to_CPU), .MIO_ready(MIO_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_dout(ram_dout), .sw(sw), .led(led), .cnt_zero(cnt_zero)
    );

    always #5 clk = ~clk;

    // Block RAM attached to the controller (environment, not the model).
    logic [31:0] ram_mem [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    function automatic logic [31:0] init_word(int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0003);
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:(1<<RAM_AW)-1];
    logic [15:0] model_led = 16'd0;
    logic [31:0] last_rd = 32'd0;
    logic [31:0] cnt_L = 32'd0;   // value visible in cycle cnt_t
    int          cnt_t = 0;
    bit          we_expected = 1'b0;
    logic [31:0] we_din;
    logic [RAM_AW-1:0] we_addr;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Counter value during cycle c: counts down one per cycle from the load, floor 0.
    function automatic logic [31:0] cnt_at(int c);
        longint el;
        el = longint'(c) - longint'(cnt_t);
        if (el < 0) el = 0;
        return (longint'(cnt_L) > el) ? 32'(longint'(cnt_L) - el) : 32'd0;
    endfunction

    typedef struct {
        bit          rd;
        bit          ramw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] led;
        int          due;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("cnt_zero", {31'd0, cnt_zero}, {31'd0, cnt_at(cyc) == 32'd0});
            if (ram_we) begin
                if (!we_expected) begin
                    chk("ram_we_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("ram_addr", 32'(ram_addr), 32'(we_addr));
                    chk("ram_din", ram_din, we_din);
                    we_expected = 1'b0;
                end
            end
            if (MIO_ready) begin
                if (sb.size() == 0) begin
                    chk("ready_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 32'(cyc), 32'(e.due));
                    chk("data_to_cpu", Data_to_CPU, e.data);
                    chk("led", {16'd0, led}, {16'd0, e.led});
                    if (e.ramw) chk("ram_we_issued", {31'd0, we_expected}, 32'd0);
                    $display("[TB] txn %s addr=%h data=%h led=%h cycle=%0d",
                             e.rd ? "RD" : "WR", e.addr, Data_to_CPU, led, cyc);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1 with the DUT idle; returns the same way.
    task automatic do_txn(input bit w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   k;
        int   n;
        logic [3:0] region;
        k      = cyc;
        region = a[31:28];
        e.rd   = !w;
        e.ramw = w && (region == 4'h0);
        e.addr = a;
        e.due  = k + ((region == 4'h0) ? 1 + RAM_WAIT : 1);
        if (!w) begin
            case (region)
                4'h0:    last_rd = ref_mem[a[RAM_AW+1:2]];
                4'hE:    last_rd = {16'h0000, sw};
                4'hF:    last_rd = cnt_at(k);
                default: last_rd = 32'd0;
            endcase
        end else begin
            if (region == 4'hE) model_led = d[15:0];
            if (region == 4'h0) begin
                ref_mem[a[RAM_AW+1:2]] = d;
                we_expected = 1'b1;
                we_addr     = a[RAM_AW+1:2];
                we_din      = d;
            end
        end
        e.data = last_rd;
        e.led  = model_led;
        sb.push_back(e);
        CPU_MIO       = 1'b1;
        mem_w         = w;
        Addr_bus      = a;
        Data_from_CPU = d;
        @(posedge clk);
        #1;
        if (w && region == 4'hF) begin
            cnt_L = d;
            cnt_t = cyc;
        end
        n = 0;
        while (!MIO_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!MIO_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        CPU_MIO = 1'b0;
        repeat (1 + $urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        model_led   = 16'd0;
        cnt_L       = 32'd0;
        cnt_t       = cyc;
        last_rd     = 32'd0;
        we_expected = 1'b0;
        sb.delete();
    endtask

    // Asynchronous reset asserted mid-cycle; checked before the next edge.
    task automatic do_reset_mid();
        #2;
        reset   = 1'b1;
        CPU_MIO = 1'b0;
        model_reset();
        #1;
        chk("rst_mio_ready", {31'd0, MIO_ready}, 32'd0);
        chk("rst_led", {16'd0, led}, 32'd0);
        chk("rst_cnt_zero", {31'd0, cnt_zero}, 32'd1);
        chk("rst_data", Data_to_CPU, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // RAM write aborted by reset during its first WAIT cycle.
    task automatic do_abort(input int idx);
        logic [31:0] a;
        a = 32'(idx) << 2;
        CPU_MIO       = 1'b1;
        mem_w         = 1'b1;
        Addr_bus      = a;
        Data_from_CPU = ~ref_mem[idx];
        @(posedge clk);
        #2;
        reset   = 1'b1;
        CPU_MIO = 1'b0;
        model_reset();
        #1;
        chk("abort_ram_we", {31'd0, ram_we}, 32'd0);
        chk("abort_ready", {31'd0, MIO_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        do_txn(1'b0, a, 32'd0);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [31:0] a;
        logic [31:0] d;
        int          r;
        for (int i = 0; i < (1 << RAM_AW); i++) begin
            ram_mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("init_data", Data_to_CPU, 32'd0);
        chk("init_ready", {31'd0, MIO_ready}, 32'd0);
        chk("init_led", {16'd0, led}, 32'd0);

        // RAM write then read back
        do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        do_txn(1'b0, 32'h0000_0010, 32'd0);
        // IO port
        sw = 16'h1234;
        do_txn(1'b0, 32'hE000_0000, 32'd0);
        do_txn(1'b1, 32'hE000_0000, 32'hFFFF_00A5);
        // Counter: load, read mid-count, reload while counting, run out
        do_txn(1'b1, 32'hF000_0000, 32'd5);
        do_txn(1'b0, 32'hF000_0000, 32'd0);
        do_txn(1'b1, 32'hF000_0000, 32'd9);
        do_txn(1'b0, 32'hF000_0004, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        do_txn(1'b0, 32'hF000_0000, 32'd0);
        // Unmapped
        do_txn(1'b0, 32'h5000_0000, 32'd0);
        do_txn(1'b1, 32'h5000_0000, 32'h1234_5678);
        do_txn(1'b0, 32'hF000_0000, 32'd0);
        do_txn(1'b0, 32'h0000_0010, 32'd0);
        // Reset mid-cycle, then reset during a RAM write
        do_txn(1'b1, 32'hE000_0000, 32'h0000_5A5A);
        do_txn(1'b1, 32'hF000_0000, 32'd20);
        do_reset_mid();
        do_abort(4);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            rnd = $urandom;
            sw  = rnd[31:16];
            r   = $urandom_range(0, 3);
            rnd = $urandom;
            case (r)
                0:       a = {4'h0, rnd[27:0]};
                1:       a = {4'hE, rnd[27:0]};
                2:       a = {4'hF, rnd[27:0]};
                default: a = {4'($urandom_range(1, 13)), rnd[27:0]};
            endcase
            d = (r == 2) ? 32'($urandom_range(0, 24)) : $urandom;
            do_txn(1'($urandom_range(0, 1)), a, d);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
